// File: rtl/muldiv_unit.sv
// Iterative radix-2 integer multiply/divide unit (RV64M-style ops, incl. 32-bit "W" forms).
// Latency: N+1 cycles fire-to-o_valid (N = XLEN, or 32 for word ops); 1 cycle for div-by-zero / signed overflow.
// Backpressure: single request in flight; o_ready only in IDLE, result held in DONE until i_ready.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_valid / o_ready     request handshake (i_src1, i_src2, i_opt, i_word captured on fire)
//   i_flush               abandon whatever is in flight, back to IDLE next edge
//   o_valid / i_ready     result handshake, o_result is zero whenever o_valid is low
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int OPT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [XLEN-1:0]  i_src1,
  input  logic [XLEN-1:0]  i_src2,
  input  logic [OPT_W-1:0] i_opt,
  input  logic             i_word,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;     // product (mul) or partial remainder in low XLEN+1 bits (div)
  logic [2*XLEN-1:0] mcand;   // left-shifting multiplicand (mul) or divisor in low bits (div)
  logic [XLEN-1:0]   mplier;  // right-shifting multiplier (mul) or dividend/quotient shifter (div)
  logic [2:0]        op_q;
  logic              word_q;
  logic              zero_q;  // word form of an op that has no word variant: result forced to 0
  logic              neg_q;   // final magnitude must be negated

  // ---------------------------------------------------------------- request decode
  logic [2:0]      op_in;
  logic            s1_signed, s2_signed, is_div_in, zero_in;
  logic [XLEN-1:0] a_w, b_w, mag1, mag2;
  logic            sign1, sign2, min_in, div_zero, div_ovf, skip;

  always_comb begin
    op_in     = i_opt[2:0];
    s1_signed = (op_in != 3'd3) && (op_in != 3'd5) && (op_in != 3'd7);
    s2_signed = (op_in == 3'd0) || (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
    is_div_in = op_in[2];
    zero_in   = i_word && ((XLEN == 32) || (op_in == 3'd1) || (op_in == 3'd2) || (op_in == 3'd3));

    // Operands at the active width, extended to XLEN according to their signedness.
    a_w = i_src1;
    b_w = i_src2;
    if (i_word) begin
      a_w       = {XLEN{s1_signed & i_src1[31]}};
      a_w[31:0] = i_src1[31:0];
      b_w       = {XLEN{s2_signed & i_src2[31]}};
      b_w[31:0] = i_src2[31:0];
    end

    sign1 = s1_signed & a_w[XLEN-1];
    sign2 = s2_signed & b_w[XLEN-1];
    mag1  = sign1 ? (-a_w) : a_w;
    mag2  = sign2 ? (-b_w) : b_w;

    min_in   = i_word ? (a_w[31:0] == 32'h8000_0000) : (a_w == {1'b1, {(XLEN-1){1'b0}}});
    div_zero = is_div_in && !zero_in && (b_w == '0);
    // Signed ops only (DIV=4, REM=6 have op bit 0 clear); sign-extended -1 is all ones at either width.
    div_ovf  = is_div_in && !zero_in && !op_in[0] && min_in && (b_w == '1);
    skip     = div_zero || div_ovf;
  end

  // ---------------------------------------------------------------- FSM
  logic [CW-1:0] n_last;
  assign n_last = word_q ? CW'(31) : CW'(XLEN - 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (!i_flush && i_valid) state_nxt = skip ? DONE : CALC;
      end
      CALC: begin
        if (i_flush)            state_nxt = IDLE;
        else if (cnt == n_last) state_nxt = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_flush || i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- iteration datapath
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_ok;
  logic [XLEN:0]   div_rem;

  always_comb begin
    div_shift = {acc[XLEN-1:0], mplier[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mcand[XLEN-1:0]};
    div_ok    = !div_diff[XLEN+1];
    // Restoring step: keep the difference only when it did not borrow.
    div_rem   = div_ok ? div_diff[XLEN:0] : div_shift;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      op_q   <= '0;
      word_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && !i_flush) begin
            op_q   <= op_in;
            word_q <= i_word;
            zero_q <= zero_in;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            if (div_zero) begin
              // Quotient all ones, remainder = dividend; formatting below handles word sign-extension.
              acc    <= {{XLEN{1'b0}}, a_w};
              mplier <= '1;
              neg_q  <= 1'b0;
            end else if (div_ovf) begin
              mplier <= a_w;
              neg_q  <= 1'b0;
            end else if (is_div_in) begin
              mcand  <= {{XLEN{1'b0}}, mag2};
              // Word dividends are aligned to the top so the MSB-first shifter starts at bit 31.
              mplier <= i_word ? (mag1 << (XLEN - 32)) : mag1;
              neg_q  <= op_in[1] ? sign1 : (sign1 ^ sign2);
            end else begin
              mcand  <= {{XLEN{1'b0}}, mag1};
              mplier <= mag2;
              neg_q  <= sign1 ^ sign2;
            end
          end
        end
        CALC: begin
          if (!i_flush) begin
            cnt <= cnt + CW'(1);
            if (op_q[2]) begin
              acc    <= {{(XLEN-1){1'b0}}, div_rem};
              mplier <= {mplier[XLEN-2:0], div_ok};
            end else begin
              if (mplier[0]) acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- result formatting
  // Registers are frozen in DONE, so this combinational view is stable until the handshake.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, quo, rem, raw, fmt;

  always_comb begin
    prod    = neg_q ? (-acc) : acc;
    mul_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo     = neg_q ? (-mplier) : mplier;
    rem     = neg_q ? (-acc[XLEN-1:0]) : acc[XLEN-1:0];
    raw     = op_q[2] ? (op_q[1] ? rem : quo) : mul_res;
    fmt     = raw;
    if (word_q) begin
      fmt       = {XLEN{raw[31]}};
      fmt[31:0] = raw[31:0];
    end
    if (zero_q) fmt = '0;
    o_result = (state == DONE) ? fmt : '0;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=64): vector table plus hand-written sequences.
// Latency: measured per op in cycles from the fire edge to o_valid.
// Backpressure: exercises held i_ready, flush in CALC/DONE/IDLE and async reset mid-CALC.
module tb_muldiv_unit;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [XLEN-1:0] i_src1 = '0;
  logic [XLEN-1:0] i_src2 = '0;
  logic [2:0]      i_opt = '0;
  logic            i_word = 1'b0;
  logic            i_flush = 1'b0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [XLEN-1:0] o_result;

  muldiv_unit #(.XLEN(XLEN), .OPT_W(3)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_src1  (i_src1),
    .i_src2  (i_src2),
    .i_opt   (i_opt),
    .i_word  (i_word),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic        w;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  function automatic void add(string name, logic [63:0] a, logic [63:0] b, logic [2:0] op,
                              logic w, logic [63:0] exp, int lat);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.op = op; v.w = w; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Fire one request and wait (bounded) for o_valid; lat counts edges from the fire edge.
  task automatic fire_wait(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                           input logic w, output logic [63:0] res, output int lat);
    @(negedge clk);
    check("ready_before_fire", {63'd0, o_ready}, 64'd1);
    i_valid = 1'b1; i_src1 = a; i_src2 = b; i_opt = op; i_word = w;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = o_result;
  endtask

  task automatic handshake();
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  logic [63:0] res;
  int          lat;
  int          bad;

  initial begin
    // ---- table
    add("mul_m1x2",     64'hFFFF_FFFF_FFFF_FFFF, 64'd2, MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    add("mulhu_m1x2",   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, MULHU,  1'b0, 64'h1,                   65);
    add("mulh_m1x2",    64'hFFFF_FFFF_FFFF_FFFF, 64'd2, MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add("mulhsu_m1x2",  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add("mul_m3x5",     64'hFFFF_FFFF_FFFF_FFFD, 64'd5, MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFF1, 65);
    add("mulh_m3x5",    64'hFFFF_FFFF_FFFF_FFFD, 64'd5, MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add("mul_2p32sq",   64'h1_0000_0000, 64'h1_0000_0000, MUL,   1'b0, 64'h0,                   65);
    add("mulhu_2p32sq", 64'h1_0000_0000, 64'h1_0000_0000, MULHU, 1'b0, 64'h1,                   65);
    add("div_m7_2",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add("rem_m7_2",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add("div_7_m2",     64'd7, 64'hFFFF_FFFF_FFFF_FFFE, DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add("rem_7_m2",     64'd7, 64'hFFFF_FFFF_FFFF_FFFE, REM,    1'b0, 64'd1,                   65);
    add("divu_100_7",   64'd100, 64'd7, DIVU,                   1'b0, 64'd14,                  65);
    add("remu_100_7",   64'd100, 64'd7, REMU,                   1'b0, 64'd2,                   65);
    add("divu_5_0",     64'd5, 64'd0, DIVU,                     1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add("remu_5_0",     64'd5, 64'd0, REMU,                     1'b0, 64'd5,                   1);
    add("div_ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, DIV, 1'b0, 64'h8000_0000_0000_0000, 1);
    add("rem_ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, REM, 1'b0, 64'h0, 1);
    add("mulw_7fff_x2", 64'h7FFF_FFFF, 64'd2, MUL,              1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    add("mulw_m3x5",    64'hABCD_0000_FFFF_FFFD, 64'd5, MUL,    1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 33);
    add("divw_ovf",     64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
    add("remw_ovf",     64'h0000_0000_8000_0000, 64'h5555_5555_FFFF_FFFF, REM, 1'b1, 64'h0, 1);
    add("divuw",        64'h0000_0001_FFFF_FFFF, 64'h10, DIVU,  1'b1, 64'h0000_0000_0FFF_FFFF, 33);
    add("remuw",        64'h0000_0001_FFFF_FFFF, 64'h10, REMU,  1'b1, 64'h0000_0000_0000_000F, 33);
    add("divuw_by0",    64'hFFFF_FFFF, 64'hFFFF_0000_0000_0000, DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add("remw_by0",     64'h0000_0000_8000_0005, 64'd0, REM,    1'b1, 64'hFFFF_FFFF_8000_0005, 1);
    add("mulhw_zero",   64'h7FFF_FFFF, 64'h7FFF_FFFF, MULH,     1'b1, 64'h0,                   33);

    // ---- reset state, no clock edge yet
    #2;
    check("rst_o_ready",  {63'd0, o_ready},  64'd1);
    check("rst_o_valid",  {63'd0, o_valid},  64'd0);
    check("rst_o_result", o_result,          64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      fire_wait(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].w, res, lat);
      check({vecs[i].name, "_res"}, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
      handshake();
    end

    // ---- held i_ready in DONE
    fire_wait(64'd100, 64'd7, DIVU, 1'b0, res, lat);
    check("bp_first_res", res, 64'd14);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (o_result !== 64'd14 || o_valid !== 1'b1 || o_ready !== 1'b0) bad++;
    end
    check("bp_hold_stable", 64'(bad), 64'd0);
    @(negedge clk);
    i_ready = 1'b1;
    check("bp_valid_at_hs", {63'd0, o_valid}, 64'd1);
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("bp_valid_after_hs", {63'd0, o_valid}, 64'd0);
    check("bp_ready_after_hs", {63'd0, o_ready}, 64'd1);

    // ---- flush at CALC iteration 20
    fire_wait_flush: begin
      @(negedge clk);
      i_valid = 1'b1; i_src1 = 64'hFFFF_FFFF_FFFF_FFFF; i_src2 = 64'd2; i_opt = MUL; i_word = 1'b0;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      check("flush_calc_ready",  {63'd0, o_ready}, 64'd1);
      check("flush_calc_result", o_result, 64'd0);
      bad = 0;
      for (int k = 0; k < 80; k++) begin
        @(posedge clk); #1;
        if (o_valid !== 1'b0) bad++;
      end
      check("flush_calc_no_valid", 64'(bad), 64'd0);
    end

    // ---- flush in DONE discards the result
    fire_wait(64'd5, 64'd0, DIVU, 1'b0, res, lat);
    check("flush_done_pre", {63'd0, o_valid}, 64'd1);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_done_valid",  {63'd0, o_valid}, 64'd0);
    check("flush_done_result", o_result, 64'd0);

    // ---- flush beats a simultaneous fire
    @(negedge clk);
    i_valid = 1'b1; i_flush = 1'b1; i_src1 = 64'd5; i_src2 = 64'd0; i_opt = DIVU;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_fire_ready", {63'd0, o_ready}, 64'd1);
    check("flush_fire_valid", {63'd0, o_valid}, 64'd0);

    // ---- async reset pulse mid-CALC
    @(negedge clk);
    i_valid = 1'b1; i_src1 = 64'd123; i_src2 = 64'd456; i_opt = MUL; i_word = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready",  {63'd0, o_ready}, 64'd1);
    check("arst_valid",  {63'd0, o_valid}, 64'd0);
    check("arst_result", o_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fire_wait(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, MUL, 1'b0, res, lat);
    check("post_rst_res", res, 64'hFFFF_FFFF_FFFF_FFF1);
    check("post_rst_lat", 64'(lat), 64'd65);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time exceeded, expected completion");
    $fatal(1, "timeout");
  end

endmodule
